// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and defaults for the data memory controller.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_DRAIN = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_DONE  = 2'd3
    } state_t;

    localparam int          DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/data_mem_ctrl_write_buffer.sv
// One-entry posted write buffer with word-address match against a load address.
module write_buffer
    import data_mem_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [31:0] i_cmp_addr,
    output logic        o_valid,
    output logic        o_hit,
    output logic [31:0] o_addr,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= word_align(i_addr);
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_hit   = r_valid && (r_addr == word_align(i_cmp_addr));

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU data-side memory controller: posted write buffer, blocking loads, ack timeout.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_read,
    input  logic        i_cpu_write,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_bus_err
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_bus_err;

    logic        w_buf_valid;
    logic        w_buf_hit;
    logic [31:0] w_buf_addr;
    logic [31:0] w_buf_data;
    logic        w_rd_hit;
    logic        w_rd_miss;
    logic        w_wr;
    logic        w_stall;
    logic        w_load;
    logic        w_clear;
    logic        w_ack;
    logic        w_timeout;
    logic [31:0] w_rdata;

    // A simultaneous read and write is served as a read only.
    assign w_rd_hit  = i_cpu_read && w_buf_hit;
    assign w_rd_miss = i_cpu_read && !w_buf_hit;
    assign w_wr      = i_cpu_write && !i_cpu_read;
    assign w_ack     = i_mem_ack && r_mem_req;
    assign w_timeout = (r_cnt == LAST);
    assign w_load    = w_wr && !w_stall;
    assign w_clear   = (r_state == ST_WR_DRAIN) && (w_ack || w_timeout);

    write_buffer u_wbuf (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_addr     (i_cpu_addr),
        .i_data     (i_cpu_wdata),
        .i_cmp_addr (i_cpu_addr),
        .o_valid    (w_buf_valid),
        .o_hit      (w_buf_hit),
        .o_addr     (w_buf_addr),
        .o_data     (w_buf_data)
    );

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE, ST_WR_DRAIN: w_stall = w_rd_miss || (w_wr && w_buf_valid);
            ST_RD_WAIT:           w_stall = 1'b1;
            default:              w_stall = 1'b0;
        endcase
        if (!i_rst_n)
            w_stall = 1'b0;
    end

    always_comb begin
        w_rdata = '0;
        if (!i_rst_n)
            w_rdata = '0;
        else if (r_state == ST_RD_DONE && i_cpu_read)
            w_rdata = r_rdata;
        else if (w_rd_hit && !w_stall)
            w_rdata = w_buf_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Buffered store always goes out before a missing load.
                    if (w_buf_valid) begin
                        r_state     <= ST_WR_DRAIN;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_buf_addr;
                        r_mem_wdata <= w_buf_data;
                        r_cnt       <= '0;
                    end else if (w_rd_miss) begin
                        r_state     <= ST_RD_WAIT;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= word_align(i_cpu_addr);
                        r_mem_wdata <= '0;
                        r_cnt       <= '0;
                    end
                end
                ST_WR_DRAIN: begin
                    if (w_ack || w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (!w_ack)
                            r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_ack) begin
                        r_state   <= ST_RD_DONE;
                        r_mem_req <= 1'b0;
                        r_rdata   <= i_mem_rdata;
                    end else if (w_timeout) begin
                        r_state   <= ST_RD_DONE;
                        r_mem_req <= 1'b0;
                        r_rdata   <= ERR_DATA;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_rdata = w_rdata;
    assign o_stall     = w_stall;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a queue of expected memory transactions.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        bus_err;

    always #5 clk = ~clk;

    data_mem_ctrl #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpu_read  (cpu_read),
        .i_cpu_write (cpu_write),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_stall     (stall),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_bus_err   (bus_err)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    txn_t        held;
    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    bit          force_ack = 1'b0;
    logic [31:0] rd_val = '0;
    logic        prev_req = 1'b0;
    int          req_cycles = 0;
    int          last_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // One clock: observe memory side just after the edge, then drive the ack model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req && !prev_req) begin
            req_cycles = 0;
            held = {mem_we, mem_addr, mem_wdata};
            chk("txn_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("txn_we", 32'(mem_we), 32'(cur.we));
                chk("txn_addr", mem_addr, cur.addr);
                chk("txn_wdata", mem_wdata, cur.wdata);
            end
        end else if (mem_req) begin
            chk("txn_stable", 32'({mem_we, mem_addr, mem_wdata} == held), 32'd1);
        end
        if (!mem_req && prev_req)
            last_len = req_cycles;
        if (mem_req)
            req_cycles++;
        mem_ack   = force_ack || (mem_req && ack_en && (req_cycles > ack_delay));
        mem_rdata = rd_val;
        prev_req  = mem_req;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input int exp_stall);
        int n;
        exp_q.push_back(txn_t'{1'b1, align(a), d});
        cpu_write = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
        n = 0;
        while (stall && n < 50) begin
            tick();
            #1;
            n++;
        end
        chk("st_stall_cycles", 32'(n), 32'(exp_stall));
        tick();
        cpu_write = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp_d, input int exp_stall,
                        input bit expect_txn, input bit also_write);
        int n;
        if (expect_txn)
            exp_q.push_back(txn_t'{1'b0, align(a), 32'd0});
        cpu_read  = 1'b1;
        cpu_write = also_write;
        cpu_wdata = 32'hBAD0BAD0;
        cpu_addr  = a;
        #1;
        n = 0;
        while (stall && n < 50) begin
            tick();
            #1;
            n++;
        end
        chk("ld_stall_cycles", 32'(n), 32'(exp_stall));
        chk("ld_rdata", cpu_rdata, exp_d);
        tick();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        #1;
        chk("rdata_zero_idle", cpu_rdata, 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cpu_read = 1'b1;
        cpu_addr = 32'h0000_0900;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        cpu_read = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Posted store, ack two cycles after request
        ack_delay = 2;
        store(32'h40, 32'h11223344, 0);
        repeat (6) tick();
        chk("wr_drain_len", 32'(last_len), 32'd3);
        chk("wr_bus_err", 32'(bus_err), 32'd0);

        // Load hitting the write buffer
        ack_delay = 0;
        store(32'h80, 32'h000000A5, 0);
        load(32'h82, 32'h000000A5, 0, 1'b0, 1'b0);
        repeat (4) tick();
        chk("hit_no_read_txn", 32'(exp_q.size()), 32'd0);

        // Zero-wait load
        rd_val = 32'hCAFE0001;
        load(32'h100, 32'hCAFE0001, 2, 1'b1, 1'b0);

        // Pending store drained before load miss
        ack_delay = 1;
        rd_val = 32'h12345678;
        store(32'h10, 32'h5555AAAA, 0);
        load(32'h20, 32'h12345678, 6, 1'b1, 1'b0);
        chk("order_drained", 32'(exp_q.size()), 32'd0);

        // Store into a full buffer waits for the drain
        store(32'h300, 32'h0A0A0A0A, 0);
        store(32'h304, 32'h0B0B0B0B, 3);
        repeat (5) tick();
        chk("full_drained", 32'(exp_q.size()), 32'd0);

        // Read and write together behave as a read only
        ack_delay = 0;
        rd_val = 32'h0F0F0F0F;
        load(32'h400, 32'h0F0F0F0F, 2, 1'b1, 1'b1);
        repeat (3) tick();
        chk("rw_no_write", 32'(exp_q.size()), 32'd0);

        // Read timeout
        ack_en = 1'b0;
        load(32'h200, 32'hDEADBEEF, 5, 1'b1, 1'b0);
        chk("to_req_len", 32'(last_len), 32'd4);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        ack_en = 1'b1;
        rd_val = 32'h600DF00D;
        load(32'h204, 32'h600DF00D, 2, 1'b1, 1'b0);
        chk("bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset during RD_WAIT, late ack afterwards
        ack_en = 1'b0;
        exp_q.push_back(txn_t'{1'b0, 32'h500, 32'd0});
        cpu_read = 1'b1;
        cpu_addr = 32'h500;
        tick();
        tick();
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_bus_err", 32'(bus_err), 32'd0);
        chk("midrst_rdata", cpu_rdata, 32'd0);
        cpu_read = 1'b0;
        tick();
        rst_n = 1'b1;
        force_ack = 1'b1;
        rd_val = 32'h99999999;
        tick();
        tick();
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        force_ack = 1'b0;
        ack_en = 1'b1;
        rd_val = 32'h77778888;
        load(32'h600, 32'h77778888, 2, 1'b1, 1'b0);

        repeat (3) tick();
        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
